ksa_pipe_adder: RTL and testbench
=================================

Name: ksa_pipe_adder

Overview:
- Pipelined WIDTH-bit Kogge-Stone adder with a valid/ready stream interface on both sides.
- Per bit, it generates p = a^b and g = a&b. It then runs log2(WIDTH) prefix levels using the (g0&p1)|g1 and p0&p1 combine.
- A post stage forms the carries c[i] = G[i-1:0] | (P[i-1:0] & cin), then sum and cout.
- Sits between the operand source and the result consumer. Throughput is one add per clock when not back-pressured.

Parameters:
- WIDTH, 16, operand width. Must be a power of 2 and at least 2. Other values are an elaboration error.
- LEVELS, log2(WIDTH), number of prefix levels. Derived locally, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a+b+cin, low WIDTH bits
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow: c[WIDTH-1] ^ cout
- busy  output  1  any pipeline stage holds a valid token

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear. out_valid=0, sum=0, cout=0, ovf=0, busy=0. in_ready=1 as soon as reset deasserts.
- Pipeline stages and what each register holds:
  - S0 (pre-proc register): p[WIDTH], g[WIDTH], cin.
  - S1..S_LEVELS (one register per prefix level): group P/G vectors, original p vector, cin.
  - OUT register: sum, cout, ovf.
- Every stage carries a valid bit.
- Prefix level i (distance d = 2^(i-1)):
  - For bit j >= d: G'[j] = G[j] | (P[j] & G[j-d]) and P'[j] = P[j] & P[j-d].
  - For bit j < d: values pass through unchanged.
- Stall is global:
  - advance = !out_valid | out_ready.
  - in_ready = advance. It is combinational from out_valid and out_ready only, never from in_valid.
  - When advance=0, every stage register, including its valid bit, holds its value.
- Accept and latency:
  - Operands are accepted on a rising edge where in_valid & in_ready.
  - If accepted at edge k with no stall, the result appears in OUT at edge k+LEVELS+1. For WIDTH=16 that is k+5.
  - Each stall cycle adds exactly one cycle of latency.
- Bubbles:
  - A cycle with in_valid=0 and advance=1 loads S0 valid=0.
  - Bubbles are not collapsed; they travel down the pipe.
- Output:
  - out_valid reflects the OUT valid bit.
  - sum, cout and ovf are registered and stay stable while out_valid & !out_ready.
  - When out_valid=0, sum/cout/ovf hold their last value; consumers must not use them.
- Ordering: results leave in acceptance order. No drop, no duplication.
- busy = OR of the valid bits of all stages, including OUT.
- Arithmetic:
  - {cout,sum} = a + b + cin, evaluated exactly at WIDTH+1 bits.
  - ovf = signed overflow for two's-complement operands.
- Boundary cases:
  - a=b=all-ones, cin=1 gives sum = all-ones and cout=1.
  - A carry chain that ripples through every bit must resolve within the LEVELS stages.
  - Simultaneous out_ready and in_valid with OUT valid and the pipe full: the OUT result is consumed and new operands are accepted on the same edge (full throughput).
- Reset mid-operation: all in-flight tokens are discarded. No result from before reset ever appears afterwards.

Test Plan:
- Basic add and latency, WIDTH=16, out_ready=1: a=0x1234, b=0x4321, cin=0 accepted at edge k -> out_valid first high after edge k+5 with sum=0x5555, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: stream 8 back-to-back operands and hold out_ready=0 for 3 cycles once out_valid rises -> in_ready=0 during those cycles, sum stable, no loss or reorder; all 8 results correct and in order; one result per cycle after release.
- Bubbles and busy: alternate in_valid 1/0 for 6 cycles -> out_valid alternates with the same pattern 5 cycles later. busy drops to 0 one cycle after the last result is taken.
- Reset mid-stream: assert rst_n=0 asynchronously while 3 tokens are in flight -> out_valid=0 and busy=0 immediately; after release, no stale result emerges. A new add of 0x0001+0x0001 yields 0x0002 at k+5.

Source files
------------

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder: a pre-processing stage, one register per prefix level,
// then a carry/sum stage into the output register. Valid/ready stream on both sides.
module ksa_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int LEVELS = $clog2(WIDTH);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("ksa_pipe_adder: WIDTH must be a power of 2 and at least 2");
    end

    // One Kogge-Stone prefix level at span d; bits below d pass through.
    function automatic logic [2*WIDTH-1:0] ksa_level(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input int               d
    );
        logic [WIDTH-1:0] g_n;
        logic [WIDTH-1:0] p_n;
        g_n = g;
        p_n = p;
        for (int j = 0; j < WIDTH; j++) begin
            if (j >= d) begin
                g_n[j] = g[j] | (p[j] & g[j-d]);
                p_n[j] = p[j] & p[j-d];
            end
        end
        return {g_n, p_n};
    endfunction

    // Index 0 is the pre-processing stage, index l the output of prefix level l.
    logic [WIDTH-1:0] gen_p  [0:LEVELS];
    logic [WIDTH-1:0] prop_p [0:LEVELS];
    logic [WIDTH-1:0] half_p [0:LEVELS];
    logic             cin_p  [0:LEVELS];
    logic [LEVELS:0]  vld_p;

    logic             out_vld;
    logic             advance;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;
    logic             ovf_nxt;

    // The stall is global: every stage moves together or holds together.
    assign advance   = !out_vld || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_vld;
    assign busy      = (|vld_p) || out_vld;

    // ---- stage boundary: operands -> S0, S(l-1) -> S(l) ----
    always_ff @(posedge clk) begin
        if (advance) begin
            gen_p[0]  <= a & b;
            prop_p[0] <= a ^ b;
            half_p[0] <= a ^ b;
            cin_p[0]  <= cin;
            for (int l = 1; l <= LEVELS; l++) begin
                {gen_p[l], prop_p[l]} <= ksa_level(gen_p[l-1], prop_p[l-1], 1 << (l - 1));
                half_p[l] <= half_p[l-1];
                cin_p[l]  <= cin_p[l-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (advance) begin
            vld_p <= {vld_p[LEVELS-1:0], in_valid};
        end
    end

    // After the last level gen/prop hold the full prefix G[i:0]/P[i:0].
    always_comb begin
        carry    = '0;
        carry[0] = cin_p[LEVELS];
        for (int i = 1; i <= WIDTH; i++) begin
            carry[i] = gen_p[LEVELS][i-1] | (prop_p[LEVELS][i-1] & cin_p[LEVELS]);
        end
        sum_nxt  = half_p[LEVELS] ^ carry[WIDTH-1:0];
        cout_nxt = carry[WIDTH];
        ovf_nxt  = carry[WIDTH-1] ^ carry[WIDTH];
    end

    // ---- stage boundary: S(LEVELS) -> OUT ----
    // Bubbles leave the result fields untouched so they keep the last real value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (advance) begin
            out_vld <= vld_p[LEVELS];
            if (vld_p[LEVELS]) begin
                sum  <= sum_nxt;
                cout <= cout_nxt;
                ovf  <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Randomised and directed bench for ksa_pipe_adder (WIDTH=16) against an
// arithmetic reference model and an in-order expectation queue.
module tb_ksa_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [17:0] sb [$];
    logic        held = 1'b0;
    logic [17:0] held_val = '0;

    ksa_pipe_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    // {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] s;
        logic        o;
        s = {1'b0, x} + {1'b0, y} + {16'd0, c};
        o = (x[15] == y[15]) && (s[15] != x[15]);
        return {o, s};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard / protocol checker, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (out_valid) chk("busy_with_out", {31'd0, busy}, 32'd1);
            if (held && out_valid) chk("hold_stable", {14'd0, ovf, cout, sum}, {14'd0, held_val});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("result", {14'd0, ovf, cout, sum}, {14'd0, sb.pop_front()});
                end
            end
            held = out_valid && !out_ready;
            held_val = {ovf, cout, sum};
            if (in_valid && in_ready) sb.push_back(model(a, b, cin));
        end else begin
            held = 1'b0;
        end
    end

    task automatic single(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          input logic [15:0] es, input logic ec, input logic eo, input string nm);
        int n;
        @(posedge clk); #1;
        a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, 5);
        chk({nm, "_sum"}, {16'd0, sum}, {16'd0, es});
        chk({nm, "_cout"}, {31'd0, cout}, {31'd0, ec});
        chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    logic [15:0] corner [0:5] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h5555};

    function automatic logic [15:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    initial begin
        int i, cyc, stall_left, post_out, post_cyc;
        bit started, acc;
        bit pat [0:5];
        bit ov [0:15];
        bit bz [0:15];

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed arithmetic with literal expectations
        single(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "basic");
        single(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
        single(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, "ones_cin");
        single(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
        single(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");
        single(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, "cin_ripple");

        // Backpressure: 8 back-to-back, 3-cycle stall as soon as out_valid rises
        i = 0; cyc = 0; stall_left = 0; started = 0; post_out = 0; post_cyc = 0;
        a = rnd_op(); b = rnd_op(); cin = 1'($urandom);
        while ((i < 8 || sb.size() != 0) && cyc < 100) begin
            in_valid = (i < 8);
            if (!started && out_valid) begin
                started = 1; stall_left = 3;
            end
            out_ready = !(stall_left > 0);
            #1;
            if (stall_left > 0) chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            if (started && stall_left == 0) begin
                post_cyc++;
                if (out_valid) post_out++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                a = rnd_op(); b = rnd_op(); cin = 1'($urandom);
            end
            if (stall_left > 0) stall_left--;
            cyc++;
        end
        chk("bp_all_out", sb.size(), 0);
        chk("bp_one_per_cycle", post_out, post_cyc);
        chk("bp_count_after_release", post_out, 8);
        drain();

        // Bubbles and busy
        pat = '{1, 0, 1, 0, 1, 0};
        out_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            in_valid = (t < 6) ? pat[t] : 1'b0;
            a = rnd_op(); b = rnd_op(); cin = 1'($urandom);
            @(posedge clk); #1;
            ov[t] = out_valid;
            bz[t] = busy;
        end
        for (int t = 0; t < 6; t++) chk("bubble_pattern", {31'd0, ov[t+5]}, {31'd0, pat[t]});
        chk("busy_last_result", {31'd0, bz[9]}, 32'd1);
        chk("busy_drop", {31'd0, bz[10]}, 32'd0);
        drain();

        // Reset with three tokens in flight
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1; a = rnd_op(); b = rnd_op(); cin = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            chk("no_stale", {31'd0, out_valid}, 32'd0);
        end
        single(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "post_rst");

        // Randomised traffic with random backpressure
        for (int t = 0; t < 400; t++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = rnd_op(); b = rnd_op(); cin = 1'($urandom);
            @(posedge clk); #1;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
